control_sequencer: RTL and testbench

- Instruction register plus microcode step counter for the 8-bit bus computer.
- Latches the opcode fetched from RAM over the bus, steps through fixed T-states, and decodes (opcode, step, flags) into the datapath control lines: MAR, RAM, A, B, ALU, flags, output register and PC.
- Sits between the RAM output (bus) and every bus-attached register.
- Replaces hand-driven ai/ao/bi/fi/eo/su stimulus.

---
 rtl/control_sequencer.sv | 135 +++++++++++++
 tb/tb_control_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Instruction register and T-state step counter for the 8-bit bus computer.
// Decodes (opcode, step, flags) into the datapath control lines each cycle.
module control_sequencer #(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         prog,
  input  logic [N-1:0] bus,
  input  logic         cf,
  input  logic         zf,
  output logic [N-1:0] irval,
  output logic [A-1:0] irarg,
  output logic [2:0]   step,
  output logic         hlt,
  output logic         mi,
  output logic         ri,
  output logic         io,
  output logic         ii,
  output logic         ai,
  output logic         ao,
  output logic         eo,
  output logic         su,
  output logic         bi,
  output logic         oi,
  output logic         ce,
  output logic         co,
  output logic         j,
  output logic         fi,
  output logic         ro_
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [N-1:0] ir_q, ir_d;
  logic [2:0]   step_q, step_d;
  logic         halted_q, halted_d;
  logic [3:0]   opcode;

  assign opcode = ir_q[N-1:N-4];
  assign irval  = ir_q;
  assign irarg  = ir_q[A-1:0];
  assign step   = step_q;

  // Control decode; prog=0 idles everything, including hlt while halted.
  always_comb begin
    hlt = 1'b0; mi = 1'b0; ri = 1'b0; io = 1'b0; ii = 1'b0;
    ai  = 1'b0; ao = 1'b0; eo = 1'b0; su = 1'b0; bi = 1'b0;
    oi  = 1'b0; ce = 1'b0; co = 1'b0; j  = 1'b0; fi = 1'b0;
    ro_ = 1'b1;
    if (prog) begin
      if (halted_q) begin
        hlt = 1'b1;
      end else begin
        case (step_q)
          T0: begin co = 1'b1; mi = 1'b1; end
          T1: begin ro_ = 1'b0; ii = 1'b1; ce = 1'b1; end
          T2: begin
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin io = 1'b1; mi = 1'b1; end
              OP_LDI: begin io = 1'b1; ai = 1'b1; end
              OP_JMP: begin io = 1'b1; j = 1'b1; end
              OP_JC:  begin io = cf; j = cf; end
              OP_JZ:  begin io = zf; j = zf; end
              OP_OUT: begin ao = 1'b1; oi = 1'b1; end
              OP_HLT: hlt = 1'b1;
              default: ;
            endcase
          end
          T3: begin
            case (opcode)
              OP_LDA: begin ro_ = 1'b0; ai = 1'b1; end
              OP_ADD, OP_SUB: begin ro_ = 1'b0; bi = 1'b1; end
              OP_STA: begin ao = 1'b1; ri = 1'b1; end
              default: ;
            endcase
          end
          T4: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
              eo = 1'b1; ai = 1'b1; fi = 1'b1;
              su = (opcode == OP_SUB);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ir_d     = ir_q;
    step_d   = step_q;
    halted_d = halted_q;
    if (ii) ir_d = bus;
    if (halted_q) begin
      step_d = T2;
    end else if (!prog) begin
      step_d = T0;
    end else if (step_q == T2 && opcode == OP_HLT) begin
      halted_d = 1'b1;
      step_d   = T2;
    end else begin
      step_d = (step_q == T4) ? T0 : step_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ir_q     <= '0;
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: stimulus pushes the expected
// per-cycle {irval, irarg, step, controls} into a queue; a monitor checks it.
module tb_control_sequencer;

  localparam int W = 31;

  // Control vector bit order: hlt mi ri io ii ai ao eo su bi oi ce co j fi ro_
  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_IO  = 16'h1000;
  localparam logic [15:0] C_II  = 16'h0800;
  localparam logic [15:0] C_AI  = 16'h0400;
  localparam logic [15:0] C_AO  = 16'h0200;
  localparam logic [15:0] C_EO  = 16'h0100;
  localparam logic [15:0] C_SU  = 16'h0080;
  localparam logic [15:0] C_BI  = 16'h0040;
  localparam logic [15:0] C_OI  = 16'h0020;
  localparam logic [15:0] C_CE  = 16'h0010;
  localparam logic [15:0] C_CO  = 16'h0008;
  localparam logic [15:0] C_J   = 16'h0004;
  localparam logic [15:0] C_FI  = 16'h0002;
  localparam logic [15:0] R     = 16'h0001;  // ro_ high (RAM not driving)
  localparam logic [15:0] IDLE  = R;

  logic       clk = 1'b0;
  logic       clr, prog, cf, zf;
  logic [7:0] bus;
  logic [7:0] irval;
  logic [3:0] irarg;
  logic [2:0] step;
  logic hlt, mi, ri, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi, ro_;

  logic [W-1:0] exp_q[$];
  logic         chk = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   cur_ir = 8'h00;
  logic [15:0]  tab[0:14][0:2];

  control_sequencer #(.N(8), .A(4)) dut (
    .clk(clk), .clr(clr), .prog(prog), .bus(bus), .cf(cf), .zf(zf),
    .irval(irval), .irarg(irarg), .step(step),
    .hlt(hlt), .mi(mi), .ri(ri), .io(io), .ii(ii), .ai(ai), .ao(ao),
    .eo(eo), .su(su), .bi(bi), .oi(oi), .ce(ce), .co(co), .j(j), .fi(fi),
    .ro_(ro_)
  );

  always #5 clk = ~clk;

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    int drv;
    if (chk) begin
      act = {irval, irarg, step, hlt, mi, ri, io, ii, ai, ao, eo, su, bi,
             oi, ce, co, j, fi, ro_};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL state_ctrl: got=%h required=<queued entry>, queue empty", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL state_ctrl @%0t: got ir=%h arg=%h step=%0d ctrl=%h, required ir=%h arg=%h step=%0d ctrl=%h",
                   $time, act[30:23], act[22:19], act[18:16], act[15:0],
                   e[30:23], e[22:19], e[18:16], e[15:0]);
        end
      end
      drv = int'(co) + int'(!ro_) + int'(io) + int'(ao) + int'(eo);
      n_vec++;
      if (drv > 1) begin
        n_err++;
        $display("FAIL bus_exclusive @%0t: got %0d drivers, required <= 1", $time, drv);
      end
    end
  end

  task automatic cyc(input logic clr_v, input logic prog_v, input logic [7:0] bus_v,
                     input logic cf_v, input logic zf_v, input logic [7:0] e_ir,
                     input logic [2:0] e_step, input logic [15:0] e_ctrl);
    clr  = clr_v;
    prog = prog_v;
    bus  = bus_v;
    cf   = cf_v;
    zf   = zf_v;
    exp_q.push_back({e_ir, e_ir[3:0], e_step, e_ctrl});
    chk = 1'b1;
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] op, input logic cf_v, input logic zf_v);
    cyc(1'b0, 1'b1, 8'hA5, cf_v, zf_v, cur_ir, 3'd0, C_CO | C_MI | R);
    cyc(1'b0, 1'b1, op,    cf_v, zf_v, cur_ir, 3'd1, C_II | C_CE);
    cur_ir = op;
  endtask

  task automatic instr(input logic [7:0] op, input logic cf_v, input logic zf_v,
                       input logic [15:0] t2, input logic [15:0] t3, input logic [15:0] t4);
    fetch(op, cf_v, zf_v);
    cyc(1'b0, 1'b1, 8'h5A, cf_v, zf_v, cur_ir, 3'd2, t2);
    cyc(1'b0, 1'b1, 8'h5A, cf_v, zf_v, cur_ir, 3'd3, t3);
    cyc(1'b0, 1'b1, 8'h5A, cf_v, zf_v, cur_ir, 3'd4, t4);
  endtask

  initial begin
    tab[0]  = '{IDLE, IDLE, IDLE};
    tab[1]  = '{C_IO | C_MI | R, C_AI, IDLE};
    tab[2]  = '{C_IO | C_MI | R, C_BI, C_EO | C_AI | C_FI | R};
    tab[3]  = '{C_IO | C_MI | R, C_BI, C_EO | C_AI | C_FI | C_SU | R};
    tab[4]  = '{C_IO | C_MI | R, C_AO | C_RI | R, IDLE};
    tab[5]  = '{C_IO | C_AI | R, IDLE, IDLE};
    tab[6]  = '{C_IO | C_J | R, IDLE, IDLE};
    tab[7]  = '{C_IO | C_J | R, IDLE, IDLE};
    tab[8]  = '{C_IO | C_J | R, IDLE, IDLE};
    tab[9]  = '{IDLE, IDLE, IDLE};
    tab[10] = '{IDLE, IDLE, IDLE};
    tab[11] = '{IDLE, IDLE, IDLE};
    tab[12] = '{IDLE, IDLE, IDLE};
    tab[13] = '{IDLE, IDLE, IDLE};
    tab[14] = '{C_AO | C_OI | R, IDLE, IDLE};

    clr = 1'b1; prog = 1'b1; bus = 8'h00; cf = 1'b0; zf = 1'b0;
    @(posedge clk);
    #1;

    // Reset state then LDA 0x1E; following T0 shows step back at 0.
    instr(8'h1E, 1'b0, 1'b0, C_IO | C_MI | R, C_AI, IDLE);

    // Arithmetic
    instr(8'h2F, 1'b0, 1'b0, C_IO | C_MI | R, C_BI, C_EO | C_AI | C_FI | R);
    instr(8'h3F, 1'b0, 1'b0, C_IO | C_MI | R, C_BI, C_EO | C_AI | C_FI | C_SU | R);

    // Conditional jumps; flag flips after T2 must not matter
    instr(8'h73, 1'b0, 1'b0, IDLE, IDLE, IDLE);
    instr(8'h73, 1'b1, 1'b0, C_IO | C_J | R, IDLE, IDLE);
    instr(8'h85, 1'b0, 1'b1, C_IO | C_J | R, IDLE, IDLE);
    instr(8'h85, 1'b1, 1'b0, IDLE, IDLE, IDLE);
    fetch(8'h73, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, cur_ir, 3'd2, IDLE);
    cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, cur_ir, 3'd3, IDLE);
    cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, cur_ir, 3'd4, IDLE);

    // Undefined opcode
    instr(8'h9A, 1'b0, 1'b0, IDLE, IDLE, IDLE);

    // Mode drop during T3 of LDA: idle now, step 0 next, ir held
    fetch(8'h1C, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, cur_ir, 3'd2, C_IO | C_MI | R);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, cur_ir, 3'd3, IDLE);
    cyc(1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, cur_ir, 3'd0, IDLE);

    // Reset during T3 of LDA
    fetch(8'h1D, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, cur_ir, 3'd2, C_IO | C_MI | R);
    cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, cur_ir, 3'd3, C_AI);
    cur_ir = 8'h00;

    // Every opcode except HLT through all five steps
    for (int i = 0; i < 15; i++) begin
      logic [7:0] op;
      op = {i[3:0], 4'h5};
      instr(op, 1'b1, 1'b1, tab[i][0], tab[i][1], tab[i][2]);
    end

    // Halt: frozen at T2, prog toggle does not release, clr does
    fetch(8'hF0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, cur_ir, 3'd2, C_HLT | R);
    for (int k = 0; k < 10; k++)
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, cur_ir, 3'd2, C_HLT | R);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, cur_ir, 3'd2, IDLE);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, cur_ir, 3'd2, IDLE);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, cur_ir, 3'd2, C_HLT | R);
    cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, cur_ir, 3'd2, C_HLT | R);
    cur_ir = 8'h00;
    instr(8'h5B, 1'b0, 1'b0, C_IO | C_AI | R, IDLE, IDLE);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, cur_ir, 3'd0, C_CO | C_MI | R);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
